// File: rtl/state_pwm_pkg.sv
// state_pwm_pkg: shared types and constants for the PWM state link
// transmitter. The receiver classifies pulse high-time into four bands;
// the band limits live here so the raw-duty option (macro
// STATE_PWM_TX_RAW_DUTY_EN) can report the state a given width decodes to.
package state_pwm_pkg;

  typedef enum logic [1:0] {
    BRAKE = 2'b00,
    SHORT = 2'b01,
    OPEN  = 2'b10,
    DRIVE = 2'b11
  } pwm_state_e;

  // Inclusive upper limits of the receiver's decode bands.
  localparam int BAND_BRAKE_MAX = 307;
  localparam int BAND_SHORT_MAX = 409;
  localparam int BAND_OPEN_MAX  = 512;

  // Default period and per-state high times.
  localparam int PERIOD_DEF  = 1024;
  localparam int W_BRAKE_DEF = 154;
  localparam int W_SHORT_DEF = 358;
  localparam int W_OPEN_DEF  = 461;
  localparam int W_DRIVE_DEF = 768;

  // State the receiver decodes from a pulse of the given high time.
  function automatic pwm_state_e width_to_state(input int width);
    if (width <= BAND_BRAKE_MAX) begin
      return BRAKE;
    end else if (width <= BAND_SHORT_MAX) begin
      return SHORT;
    end else if (width <= BAND_OPEN_MAX) begin
      return OPEN;
    end
    return DRIVE;
  endfunction

endpackage

// File: rtl/state_pwm_tx_if.sv
// state_pwm_tx_if: command handshake into the PWM transmitter.
// With STATE_PWM_TX_RAW_DUTY_EN defined the command also carries a raw
// duty width that overrides the state table.
interface state_pwm_tx_if;
  import state_pwm_pkg::*;

  logic [1:0] cmd_state;
  logic       cmd_valid;
  logic       cmd_ready;
`ifdef STATE_PWM_TX_RAW_DUTY_EN
  localparam int DUTY_W = $clog2(PERIOD_DEF);
  logic              cmd_raw;
  logic [DUTY_W-1:0] cmd_duty;
`endif

  modport master (
`ifdef STATE_PWM_TX_RAW_DUTY_EN
    output cmd_raw,
    output cmd_duty,
`endif
    output cmd_state,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
`ifdef STATE_PWM_TX_RAW_DUTY_EN
    input  cmd_raw,
    input  cmd_duty,
`endif
    input  cmd_state,
    input  cmd_valid,
    output cmd_ready
  );

endinterface

// File: rtl/state_pwm_width_lut.sv
// state_pwm_width_lut: combinational state -> high-time lookup.
// With STATE_PWM_TX_RAW_DUTY_EN defined a raw command bypasses the table:
// its duty is clamped to PERIOD-2 (so at least one low cycle remains) and the
// reported state is the band the receiver will decode from that width.
module state_pwm_width_lut
  import state_pwm_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int W_BRAKE = W_BRAKE_DEF,
  parameter int W_SHORT = W_SHORT_DEF,
  parameter int W_OPEN  = W_OPEN_DEF,
  parameter int W_DRIVE = W_DRIVE_DEF,
  localparam int CW     = $clog2(PERIOD)
) (
  input  pwm_state_e    state_i,
`ifdef STATE_PWM_TX_RAW_DUTY_EN
  input  logic          raw_i,
  input  logic [CW-1:0] duty_i,
`endif
  output logic [CW-1:0] width_o,
  output pwm_state_e    state_o
);

  logic [CW-1:0] table_width;

  // Fixed high time for each drive state.
  always_comb begin
    case (state_i)
      BRAKE:   table_width = CW'(W_BRAKE);
      SHORT:   table_width = CW'(W_SHORT);
      OPEN:    table_width = CW'(W_OPEN);
      DRIVE:   table_width = CW'(W_DRIVE);
      default: table_width = CW'(W_BRAKE);
    endcase
  end

`ifdef STATE_PWM_TX_RAW_DUTY_EN
  localparam logic [CW-1:0] MAX_W = CW'(PERIOD - 2);
  logic [CW-1:0] clamped;

  // Raw commands: clamp the duty and report the band it falls into.
  always_comb begin
    clamped = (duty_i > MAX_W) ? MAX_W : duty_i;
    if (raw_i) begin
      width_o = clamped;
      state_o = width_to_state(32'(clamped));
    end else begin
      width_o = table_width;
      state_o = state_i;
    end
  end
`else
  assign width_o = table_width;
  assign state_o = state_i;
`endif

endmodule

// File: rtl/state_pwm_tx.sv
// state_pwm_tx: sends a 2-bit drive state as the high time of a fixed-length
// PWM period. Commands land in a one-entry pending buffer and are applied
// only at a period boundary, so a pulse is never cut short or stretched.
// Optional raw-duty commands: define STATE_PWM_TX_RAW_DUTY_EN.
module state_pwm_tx
  import state_pwm_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int W_BRAKE = W_BRAKE_DEF,
  parameter int W_SHORT = W_SHORT_DEF,
  parameter int W_OPEN  = W_OPEN_DEF,
  parameter int W_DRIVE = W_DRIVE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_i,
  state_pwm_tx_if.slave cmd,
  output logic          pwm_o,
  output logic          period_start_o,
  output logic [1:0]    active_state_o,
  output logic          busy_o
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);

  // Widths must land inside their receiver bands; DRIVE leaves at least
  // one low cycle so the receiver always sees a falling edge.
  if (!(W_BRAKE <= BAND_BRAKE_MAX && BAND_BRAKE_MAX < W_SHORT &&
        W_SHORT <= BAND_SHORT_MAX && BAND_SHORT_MAX < W_OPEN &&
        W_OPEN  <= BAND_OPEN_MAX  && BAND_OPEN_MAX  < W_DRIVE &&
        W_DRIVE <= PERIOD - 2)) begin : g_bad_widths
    $error("state_pwm_tx: state widths violate receiver band limits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } fsm_e;

  fsm_e          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwm_q;
  logic          period_start_q;
  logic          transfer;      // a new period starts on this edge
  logic          accept;

  logic          pend_full_q;
  pwm_state_e    pend_state_q;
  pwm_state_e    active_state_q;
  logic [CW-1:0] active_width_q;

  pwm_state_e    lut_state;
  logic [CW-1:0] lut_width;
  logic [CW-1:0] next_width;    // width of the period that would start now

`ifdef STATE_PWM_TX_RAW_DUTY_EN
  logic          pend_raw_q;
  logic [CW-1:0] pend_duty_q;
`endif

  // The lookup works on the pending command so its width is ready at the
  // boundary edge.
  state_pwm_width_lut #(
    .PERIOD  (PERIOD),
    .W_BRAKE (W_BRAKE),
    .W_SHORT (W_SHORT),
    .W_OPEN  (W_OPEN),
    .W_DRIVE (W_DRIVE)
  ) u_lut (
    .state_i (pend_state_q),
`ifdef STATE_PWM_TX_RAW_DUTY_EN
    .raw_i   (pend_raw_q),
    .duty_i  (pend_duty_q),
`endif
    .width_o (lut_width),
    .state_o (lut_state)
  );

  assign accept        = cmd.cmd_valid && !pend_full_q;
  assign cmd.cmd_ready = !pend_full_q;
  assign next_width    = pend_full_q ? lut_width : active_width_q;

  // Next-state logic: HIGH for the active width, LOW to the end of the period.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    transfer = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          transfer = 1'b1;
          cnt_d    = '0;
          state_d  = (next_width == '0) ? LOW : HIGH;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == active_width_q - CW'(1)) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (enable_i) begin
            transfer = 1'b1;
            state_d  = (next_width == '0) ? LOW : HIGH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pwm_q          <= (state_d == HIGH);
      period_start_q <= transfer;
    end
  end

  // Pending buffer: filled by the handshake, emptied at a boundary. An
  // accept can only happen while empty, so it never collides with a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_full_q  <= 1'b0;
      pend_state_q <= BRAKE;
`ifdef STATE_PWM_TX_RAW_DUTY_EN
      pend_raw_q   <= 1'b0;
      pend_duty_q  <= '0;
`endif
    end else if (accept) begin
      pend_full_q  <= 1'b1;
      pend_state_q <= pwm_state_e'(cmd.cmd_state);
`ifdef STATE_PWM_TX_RAW_DUTY_EN
      pend_raw_q   <= cmd.cmd_raw;
      pend_duty_q  <= CW'(cmd.cmd_duty);
`endif
    end else if (transfer) begin
      pend_full_q  <= 1'b0;
    end
  end

  // Active state/width change only on a boundary edge, using the pending
  // value held before that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_state_q <= BRAKE;
      active_width_q <= CW'(W_BRAKE);
    end else if (transfer && pend_full_q) begin
      active_state_q <= lut_state;
      active_width_q <= lut_width;
    end
  end

  assign pwm_o          = pwm_q;
  assign period_start_o = period_start_q;
  assign active_state_o = active_state_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_state_pwm_tx.sv
// tb_state_pwm_tx: directed stimulus for state_pwm_tx. A period-level model
// (position in period, active/pending command) predicts every output each
// cycle; directed checks pin pulse widths and timing to literal values.
// Define STATE_PWM_TX_RAW_DUTY_EN to also exercise raw-duty commands.
module tb_state_pwm_tx;

  localparam int PERIOD = 1024;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic       pwm;
  logic       period_start;
  logic [1:0] active_state;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  state_pwm_tx_if cmd_if ();

  state_pwm_tx dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable),
    .cmd            (cmd_if),
    .pwm_o          (pwm),
    .period_start_o (period_start),
    .active_state_o (active_state),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int width_of(input int s);
    case (s)
      0:       return 154;
      1:       return 358;
      2:       return 461;
      default: return 768;
    endcase
  endfunction

  function automatic int band_of(input int w);
    if (w <= 307) return 0;
    if (w <= 409) return 1;
    if (w <= 512) return 2;
    return 3;
  endfunction

  // ---------------- period-level model ----------------
  bit m_run       = 0;  // a period is in progress
  int m_pos       = 0;  // cycle index within the period
  int m_act       = 0;
  int m_act_w     = 154;
  bit m_pend_full = 0;
  int m_pend      = 0;
  int m_pend_w    = 154;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_run = 0; m_pos = 0; m_act = 0; m_act_w = 154;
        m_pend_full = 0; m_pend = 0; m_pend_w = 154;
      end else begin
        bit acc;
        acc = cmd_if.cmd_valid && !m_pend_full;
        if (!m_run || m_pos == PERIOD - 1) begin
          if (enable) begin
            if (m_pend_full) begin
              m_act = m_pend; m_act_w = m_pend_w; m_pend_full = 0;
            end
            m_run = 1;
          end else begin
            m_run = 0;
          end
          m_pos = 0;
        end else begin
          m_pos++;
        end
        if (acc) begin
          m_pend_full = 1;
          m_pend      = int'(cmd_if.cmd_state);
          m_pend_w    = width_of(m_pend);
`ifdef STATE_PWM_TX_RAW_DUTY_EN
          if (cmd_if.cmd_raw) begin
            m_pend_w = (int'(cmd_if.cmd_duty) > PERIOD - 2) ? PERIOD - 2 : int'(cmd_if.cmd_duty);
            m_pend   = band_of(m_pend_w);
          end
`endif
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("pwm",          int'(pwm),          int'(m_run && m_pos < m_act_w));
        check("period_start", int'(period_start), int'(m_run && m_pos == 0));
        check("busy",         int'(busy),         int'(m_run));
        check("active_state", int'(active_state), m_act);
        check("cmd_ready",    int'(cmd_if.cmd_ready), int'(!m_pend_full));
      end
    end
  end

  // Monitor: length of the last high run and of the last full period.
  int run_len   = 0;
  int last_high = 0;
  int per_cnt   = 0;
  int last_per  = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        run_len = 0; per_cnt = 0;
      end else begin
        if (pwm) run_len++;
        else if (run_len > 0) begin last_high = run_len; run_len = 0; end
        if (period_start) begin
          if (per_cnt > 0) last_per = per_cnt;
          per_cnt = 1;
        end else if (per_cnt > 0) begin
          per_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] s);
    int n = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_state = s;
    while (!cmd_if.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_stall_bounded", int'(n < 3000), 1);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    $display("[%0t] cmd state=%0d accepted after %0d stall cycles", $time, s, n);
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2100);
    check("period_start_seen", int'(period_start), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_state = 2'b00;
`ifdef STATE_PWM_TX_RAW_DUTY_EN
    cmd_if.cmd_raw  = 1'b0;
    cmd_if.cmd_duty = '0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_active", int'(active_state), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_if.cmd_ready), 1);

    // Free-running with no command: BRAKE, 154 high per 1024
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("start_latency_pwm", int'(pwm), 1);
    check("start_latency_ps", int'(period_start), 1);
    wait_ps();
    check("brake_high", last_high, 154);
    check("brake_period", last_per, 1024);
    check("brake_active", int'(active_state), 0);

    // Mid-period DRIVE command
    repeat (500) @(negedge clk);
    send(2'b11);
    check("ready_low_pending", int'(cmd_if.cmd_ready), 0);
    check("active_unchanged_midperiod", int'(active_state), 0);
    wait_ps();
    check("drive_active_at_boundary", int'(active_state), 3);
    check("ready_after_boundary", int'(cmd_if.cmd_ready), 1);
    wait_ps();
    check("drive_high", last_high, 768);

    // Command accepted exactly on the boundary edge applies one period later
    repeat (1023) @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_state = 2'b00;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    $display("[%0t] cmd state=0 accepted on boundary", $time);
    check("boundary_ps", int'(period_start), 1);
    check("boundary_keeps_active", int'(active_state), 3);
    check("boundary_pending_full", int'(cmd_if.cmd_ready), 0);
    wait_ps();
    check("boundary_old_width", last_high, 768);
    check("boundary_new_active", int'(active_state), 0);
    wait_ps();
    check("boundary_new_width", last_high, 154);

    // Back-to-back SHORT then OPEN: second stalls, none lost
    repeat (10) @(negedge clk);
    send(2'b01);
    send(2'b10);
    check("b2b_first_active", int'(active_state), 1);
    wait_ps();
    check("b2b_short_high", last_high, 358);
    check("b2b_second_active", int'(active_state), 2);
    wait_ps();
    check("b2b_open_high", last_high, 461);

    // Drop enable at cnt=100 in DRIVE: period completes, then idle
    send(2'b11);
    wait_ps();
    check("drop_active", int'(active_state), 3);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    n = 100;
    while (busy && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("drop_period_len", n, 1024);
    check("drop_high", last_high, 768);
    check("drop_idle_pwm", int'(pwm), 0);
    repeat (20) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_pwm", int'(pwm), 0);
    check("idle_ps", int'(period_start), 0);

    // Reset in the middle of a high pulse with a command pending
    enable = 1'b1;
    wait_ps();
    repeat (10) @(negedge clk);
    send(2'b01);
    repeat (38) @(negedge clk);
    check("pre_reset_pwm", int'(pwm), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_active", int'(active_state), 0);
    check("async_rst_ready", int'(cmd_if.cmd_ready), 1);
    check("async_rst_ps", int'(period_start), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ps();
    check("post_rst_pending_dropped", int'(active_state), 0);
    wait_ps();
    check("post_rst_high", last_high, 154);

`ifdef STATE_PWM_TX_RAW_DUTY_EN
    // Raw duty 1023 clamps to 1022 and reports DRIVE
    cmd_if.cmd_raw  = 1'b1;
    cmd_if.cmd_duty = 10'd1023;
    send(2'b00);
    cmd_if.cmd_raw  = 1'b0;
    wait_ps();
    check("raw_active", int'(active_state), 3);
    wait_ps();
    check("raw_high", last_high, 1022);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
